// File: rtl/bus_ram_loader_pkg.sv
// Shared types, default sizes and helpers for the bus RAM with program loader.
package bus_ram_loader_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 4;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } ld_state_e;

    // Increment modulo 2**adr_w; callers truncate the result to their address width.
    function automatic logic [31:0] adr_wrap_inc(input logic [31:0] adr, input int unsigned adr_w);
        logic [31:0] mask;
        mask = (32'd1 << adr_w) - 32'd1;
        return (adr + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/bus_ram_load_fsm.sv
// Program loader: writes a handshaked word stream into RAM from address 0 while holding the CPU.
// Define BUS_RAM_LOADER_CHECKSUM_EN for a running modulo-2**DATA_W sum of accepted words.
module bus_ram_load_fsm
    import bus_ram_loader_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ld_start_i,
    input  logic              ld_valid_i,
    input  logic              ld_last_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              ld_ready_o,
    output logic              cpu_hold_o,
    output logic              ld_done_o,
    output logic [ADDR_W:0]   ld_count_o,
    output logic [DATA_W-1:0] ld_checksum_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o
);

    ld_state_e         state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              ready_q;
    logic              hold_q;
    logic              done_q;
    logic              accept;

    assign accept = ready_q && ld_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LD_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                LD_IDLE: begin
                    if (ld_start_i) begin
                        state_q <= LD_LOAD;
                        ptr_q   <= '0;
                        count_q <= '0;
                        ready_q <= 1'b1;
                        hold_q  <= 1'b1;
                    end
                end
                LD_LOAD: begin
                    if (accept) begin
                        ptr_q   <= ptr_q + 1'b1;
                        count_q <= count_q + 1'b1;
                        // The top word ends the load even without ld_last: no wrap onto address 0.
                        if (ld_last_i || (ptr_q == '1)) begin
                            state_q <= LD_DONE;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                LD_DONE: begin
                    state_q <= LD_IDLE;
                    done_q  <= 1'b0;
                    hold_q  <= 1'b0;
                end
                default: begin
                    state_q <= LD_IDLE;
                    ready_q <= 1'b0;
                    hold_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BUS_RAM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q <= '0;
        end else if ((state_q == LD_IDLE) && ld_start_i) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_q + ld_data_i;
        end
    end

    assign ld_checksum_o = sum_q;
`else
    assign ld_checksum_o = '0;
`endif

    assign ld_ready_o = ready_q;
    assign cpu_hold_o = hold_q;
    assign ld_done_o  = done_q;
    assign ld_count_o = count_q;
    assign wr_en_o    = accept;
    assign wr_addr_o  = ptr_q;
    assign wr_data_o  = ld_data_i;

endmodule

// File: rtl/bus_ram_loader.sv
// Bus-attached RAM with auto-incrementing address register and a handshaked program loader.
// Define BUS_RAM_LOADER_CHECKSUM_EN to enable the loader checksum output.
module bus_ram_loader
    import bus_ram_loader_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire logic [DATA_W-1:0] bus,
    input  logic              en_write_mem_adr,
    input  logic              en_write_mem,
    input  logic              en_read_mem,
    input  logic              en_inc_mem_adr,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic              ld_last,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              cpu_hold,
    output logic              ld_done,
    output logic [ADDR_W:0]   ld_count,
    output logic [DATA_W-1:0] ld_checksum
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] adr_q;
    logic [ADDR_W-1:0] adr_d;
    logic              cpu_en;
    logic              ld_wr_en;
    logic [ADDR_W-1:0] ld_wr_addr;
    logic [DATA_W-1:0] ld_wr_data;

    bus_ram_load_fsm #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_load_fsm (
        .clk_i        (clk),
        .rst_ni       (reset),
        .ld_start_i   (ld_start),
        .ld_valid_i   (ld_valid),
        .ld_last_i    (ld_last),
        .ld_data_i    (ld_data),
        .ld_ready_o   (ld_ready),
        .cpu_hold_o   (cpu_hold),
        .ld_done_o    (ld_done),
        .ld_count_o   (ld_count),
        .ld_checksum_o(ld_checksum),
        .wr_en_o      (ld_wr_en),
        .wr_addr_o    (ld_wr_addr),
        .wr_data_o    (ld_wr_data)
    );

    assign cpu_en = !cpu_hold;
    assign bus    = (cpu_en && en_read_mem) ? mem_q[adr_q] : 'z;

    always_comb begin
        adr_d = adr_q;
        if (ld_done) begin
            adr_d = '0;
        end else if (cpu_en) begin
            if (en_write_mem_adr) begin
                adr_d = bus[ADDR_W-1:0];
            end else if (!en_write_mem && en_inc_mem_adr) begin
                adr_d = ADDR_W'(adr_wrap_inc(32'(adr_q), ADDR_W));
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adr_q <= '0;
        end else begin
            adr_q <= adr_d;
        end
    end

    // Memory contents survive reset; the loader port only writes while the CPU is held.
    always_ff @(posedge clk) begin
        if (ld_wr_en) begin
            mem_q[ld_wr_addr] <= ld_wr_data;
        end else if (cpu_en && !en_write_mem_adr && en_write_mem) begin
            mem_q[adr_q] <= bus;
        end
    end

endmodule

// File: tb/tb_bus_ram_loader.sv
// Self-checking bench for bus_ram_loader: CPU port vectors, loader sequences, random traffic.
module tb_bus_ram_loader;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          reset;
    wire  [DW-1:0] bus;
    logic          drv_en;
    logic [DW-1:0] drv_val;
    logic          en_write_mem_adr, en_write_mem, en_read_mem, en_inc_mem_adr;
    logic          ld_start, ld_valid, ld_last;
    logic [DW-1:0] ld_data;
    logic          ld_ready, cpu_hold, ld_done;
    logic [AW:0]   ld_count;
    logic [DW-1:0] ld_checksum;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mdl_mem [DEPTH];
    int unsigned   mdl_adr;

    typedef struct {
        bit          a;
        bit          w;
        bit          inc;
        bit          rd;
        logic [7:0]  d;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl [23];

    assign bus = drv_en ? drv_val : 'z;

    bus_ram_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .en_write_mem_adr(en_write_mem_adr),
        .en_write_mem    (en_write_mem),
        .en_read_mem     (en_read_mem),
        .en_inc_mem_adr  (en_inc_mem_adr),
        .ld_start        (ld_start),
        .ld_valid        (ld_valid),
        .ld_last         (ld_last),
        .ld_data         (ld_data),
        .ld_ready        (ld_ready),
        .cpu_hold        (cpu_hold),
        .ld_done         (ld_done),
        .ld_count        (ld_count),
        .ld_checksum     (ld_checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One CPU-port cycle, entered at posedge+1. When not reading, the bench drives d and
    // expects to see exactly d back, which fails if the RAM drives the bus at the same time.
    task automatic cpu_cycle(input string name, input bit a, input bit w, input bit inc,
                             input bit rd, input logic [7:0] d, output logic [7:0] seen);
        logic [7:0] busv;
        en_write_mem_adr = a;
        en_write_mem     = w;
        en_inc_mem_adr   = inc;
        en_read_mem      = rd;
        drv_en           = !rd;
        drv_val          = d;
        #2;
        seen = bus;
        busv = rd ? mdl_mem[mdl_adr] : d;
        chk(name, {24'h0, seen}, {24'h0, busv});
        @(posedge clk); #1;
        en_write_mem_adr = 1'b0;
        en_write_mem     = 1'b0;
        en_inc_mem_adr   = 1'b0;
        en_read_mem      = 1'b0;
        drv_en           = 1'b0;
        if (a)        mdl_adr = int'(busv[3:0]);
        else if (w)   mdl_mem[mdl_adr] = busv;
        else if (inc) mdl_adr = (mdl_adr + 1) % DEPTH;
    endtask

    task automatic verify_mem(input string tag);
        logic [7:0] s;
        for (int k = 0; k < DEPTH; k++) begin
            cpu_cycle({tag, " set adr"}, 1'b1, 1'b0, 1'b0, 1'b0, 8'(k), s);
            cpu_cycle({tag, " mem read"}, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, s);
        end
    endtask

    task automatic run_load(input string tag, input logic [7:0] w[$], input bit use_last,
                            input int vmode, input bit iso, output int n_acc,
                            output logic [7:0] ck);
        int         i;
        bit         in_load;
        bit         v;
        logic [7:0] sum;
        logic [7:0] iso_val;
        i       = 0;
        in_load = 1'b1;
        sum     = 8'h00;
        iso_val = ~mdl_mem[mdl_adr];
        ld_start = 1'b1;
        @(posedge clk); #1;
        ld_start = 1'b0;
        for (int cyc = 0; cyc < 200 && in_load; cyc++) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 0;
                default: v = 1'($urandom_range(0, 1));
            endcase
            ld_valid = v && (i < w.size());
            ld_data  = (i < w.size()) ? w[i] : 8'h00;
            ld_last  = use_last && (i == w.size() - 1);
            if (iso) begin
                en_write_mem   = 1'b1;
                en_read_mem    = 1'b1;
                en_inc_mem_adr = 1'b1;
                drv_en         = 1'b1;
                drv_val        = iso_val;
            end
            #2;
            chk({tag, " ld_ready in LOAD"}, 32'(ld_ready), 32'd1);
            chk({tag, " cpu_hold in LOAD"}, 32'(cpu_hold), 32'd1);
            chk({tag, " no ld_done in LOAD"}, 32'(ld_done), 32'd0);
            chk({tag, " ld_count progress"}, 32'(ld_count), 32'(i));
            if (iso) chk({tag, " bus released while held"}, 32'(bus), 32'(iso_val));
            @(posedge clk); #1;
            if (ld_valid) begin
                mdl_mem[i] = w[i];
                sum += w[i];
                i++;
                if (ld_last || i == DEPTH) in_load = 1'b0;
            end
            ld_valid       = 1'b0;
            ld_last        = 1'b0;
            en_write_mem   = 1'b0;
            en_read_mem    = 1'b0;
            en_inc_mem_adr = 1'b0;
            drv_en         = 1'b0;
        end
        chk({tag, " load completes"}, 32'(in_load), 32'd0);
`ifdef BUS_RAM_LOADER_CHECKSUM_EN
        ck = sum;
`else
        ck = 8'h00;
`endif
        chk({tag, " ld_done in DONE"}, 32'(ld_done), 32'd1);
        chk({tag, " ld_ready in DONE"}, 32'(ld_ready), 32'd0);
        chk({tag, " cpu_hold in DONE"}, 32'(cpu_hold), 32'd1);
        chk({tag, " ld_count in DONE"}, 32'(ld_count), 32'(i));
        chk({tag, " checksum in DONE"}, 32'(ld_checksum), 32'(ck));
        @(posedge clk); #1;
        chk({tag, " ld_done one cycle"}, 32'(ld_done), 32'd0);
        chk({tag, " cpu_hold released"}, 32'(cpu_hold), 32'd0);
        chk({tag, " ld_ready idle"}, 32'(ld_ready), 32'd0);
        chk({tag, " ld_count held"}, 32'(ld_count), 32'(i));
        chk({tag, " checksum held"}, 32'(ld_checksum), 32'(ck));
        mdl_adr = 0;
        n_acc   = i;
    endtask

    initial begin
        logic [7:0] s;
        logic [7:0] q[$];
        logic [7:0] ck;
        int         n;

        tbl[0]  = '{0, 1, 0, 0, 8'h11, 8'h11};
        tbl[1]  = '{1, 0, 0, 0, 8'h00, 8'h00};
        tbl[2]  = '{0, 0, 0, 1, 8'h00, 8'h11};
        tbl[3]  = '{1, 0, 0, 0, 8'h03, 8'h03};
        tbl[4]  = '{0, 1, 0, 0, 8'hA5, 8'hA5};
        tbl[5]  = '{0, 0, 0, 1, 8'h00, 8'hA5};
        tbl[6]  = '{0, 0, 0, 0, 8'h5A, 8'h5A};
        tbl[7]  = '{1, 0, 0, 0, 8'h0F, 8'h0F};
        tbl[8]  = '{0, 1, 0, 0, 8'h3C, 8'h3C};
        tbl[9]  = '{0, 0, 1, 0, 8'hC3, 8'hC3};
        tbl[10] = '{0, 0, 0, 1, 8'h00, 8'h11};
        tbl[11] = '{1, 0, 1, 0, 8'h07, 8'h07};
        tbl[12] = '{0, 1, 0, 0, 8'h77, 8'h77};
        tbl[13] = '{0, 0, 0, 1, 8'h00, 8'h77};
        tbl[14] = '{1, 0, 0, 0, 8'h06, 8'h06};
        tbl[15] = '{0, 0, 1, 0, 8'h88, 8'h88};
        tbl[16] = '{0, 1, 0, 1, 8'h00, 8'h77};
        tbl[17] = '{0, 1, 1, 0, 8'h55, 8'h55};
        tbl[18] = '{0, 0, 0, 1, 8'h00, 8'h55};
        tbl[19] = '{1, 1, 0, 0, 8'h0F, 8'h0F};
        tbl[20] = '{0, 0, 0, 1, 8'h00, 8'h3C};
        tbl[21] = '{1, 0, 0, 0, 8'h07, 8'h07};
        tbl[22] = '{0, 0, 0, 1, 8'h00, 8'h55};

        reset = 1'b0;
        drv_en = 1'b0; drv_val = 8'h00;
        en_write_mem_adr = 1'b0; en_write_mem = 1'b0; en_read_mem = 1'b0; en_inc_mem_adr = 1'b0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 8'h00;
        mdl_adr = 0;
        for (int k = 0; k < DEPTH; k++) mdl_mem[k] = 8'h00;

        #3;
        chk("reset ld_ready", 32'(ld_ready), 32'd0);
        chk("reset cpu_hold", 32'(cpu_hold), 32'd0);
        chk("reset ld_done", 32'(ld_done), 32'd0);
        chk("reset ld_count", 32'(ld_count), 32'd0);
        chk("reset ld_checksum", 32'(ld_checksum), 32'd0);
        #9 reset = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 23; t++) begin
            cpu_cycle($sformatf("vec%0d model", t), tbl[t].a, tbl[t].w, tbl[t].inc, tbl[t].rd,
                      tbl[t].d, s);
            chk($sformatf("vec%0d table", t), 32'(s), 32'(tbl[t].exp));
        end

        for (int k = 0; k < DEPTH; k++) begin
            cpu_cycle("fill adr", 1'b1, 1'b0, 1'b0, 1'b0, 8'(k), s);
            cpu_cycle("fill data", 1'b0, 1'b1, 1'b0, 1'b0, 8'($urandom_range(1, 255)), s);
        end
        cpu_cycle("pre-load adr", 1'b1, 1'b0, 1'b0, 1'b0, 8'h09, s);
        cpu_cycle("pre-load data", 1'b0, 1'b1, 1'b0, 1'b0, 8'h69, s);

        q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        run_load("load5", q, 1'b1, 1, 1'b1, n, ck);
        chk("load5 words accepted", 32'(n), 32'd5);
`ifdef BUS_RAM_LOADER_CHECKSUM_EN
        chk("load5 checksum", 32'(ld_checksum), 32'hF0);
`else
        chk("load5 checksum", 32'(ld_checksum), 32'h00);
`endif
        cpu_cycle("adr zero after load", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, s);
        chk("adr zero after load table", 32'(s), 32'h10);
        verify_mem("after load5");

        q = {};
        for (int k = 0; k < 20; k++) q.push_back(8'(8'hB0 + k));
        run_load("full", q, 1'b0, 0, 1'b0, n, ck);
        chk("full words accepted", 32'(n), 32'd16);
        for (int k = 0; k < 3; k++) begin
            ld_valid = 1'b1;
            ld_data  = 8'hE0;
            #2;
            chk("no accept after full", 32'(ld_ready), 32'd0);
            chk("count held after full", 32'(ld_count), 32'd16);
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        verify_mem("after full");

        ld_start = 1'b1;
        @(posedge clk); #1;
        ld_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ld_valid = 1'b1;
            ld_data  = 8'(8'hC1 + k);
            @(posedge clk); #1;
            mdl_mem[k] = 8'(8'hC1 + k);
        end
        ld_valid = 1'b1;
        ld_data  = 8'hEE;
        chk("count before reset", 32'(ld_count), 32'd2);
        #1 reset = 1'b0;
        #1;
        chk("midreset cpu_hold", 32'(cpu_hold), 32'd0);
        chk("midreset ld_ready", 32'(ld_ready), 32'd0);
        chk("midreset ld_done", 32'(ld_done), 32'd0);
        chk("midreset ld_count", 32'(ld_count), 32'd0);
        reset    = 1'b1;
        ld_valid = 1'b0;
        mdl_adr  = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("no done after reset", 32'(ld_done), 32'd0);
            chk("no hold after reset", 32'(cpu_hold), 32'd0);
        end
        cpu_cycle("adr zero after reset", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, s);
        chk("adr zero after reset table", 32'(s), 32'hC1);
        verify_mem("after midreset");

        for (int r = 0; r < 4; r++) begin
            bit ul;
            int len;
            ul  = 1'($urandom_range(0, 1));
            len = ul ? int'($urandom_range(1, 20)) : int'($urandom_range(16, 20));
            q = {};
            for (int k = 0; k < len; k++) q.push_back(8'($urandom));
            run_load($sformatf("rand%0d", r), q, ul, 2, 1'($urandom_range(0, 1)), n, ck);
            for (int k = 0; k < 30; k++) begin
                bit rd;
                rd = 1'($urandom_range(0, 1));
                cpu_cycle("random cpu op", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), rd, 8'($urandom), s);
            end
        end
        verify_mem("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
